ysyx_lsu: RTL and testbench

Multi-cycle, parametrised load/store unit that replaces the execute stage's single-cycle memory path with a valid/ready handshake on both sides. It accepts one access per transaction from the execute stage and performs byte-lane alignment, write-strobe generation and load sign/zero extension. It then drives a simple request/response memory port, which can be the DPI memory model or a bus bridge, with arbitrary memory latency. It sits between the EXU and memory. The register-file writeback takes `resp_rdata`.

---
 rtl/ysyx_lsu_if.sv | 47 ++++
 rtl/ysyx_lsu.sv | 160 ++++++++++++++++
 tb/tb_ysyx_lsu.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_lsu_if.sv
// ysyx_lsu_if: request, memory-port and response signals of the load/store unit.
// The slave modport is the LSU's view; master is the EXU plus memory side driving it.
interface ysyx_lsu_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
);
    // EXU request
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    // Memory port
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN/8-1:0] mem_wstrb;
    logic              mem_resp_valid;
    logic [XLEN-1:0]   mem_rdata;
    // EXU response
    logic              resp_valid;
    logic              resp_ready;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_err;

    modport slave (
        input  req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output resp_valid, resp_rdata, resp_err,
        input  resp_ready
    );

    modport master (
        output req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  resp_valid, resp_rdata, resp_err,
        output resp_ready
    );
endinterface

// File: rtl/ysyx_lsu.sv
// ysyx_lsu: multi-cycle load/store unit with valid/ready handshakes on the EXU and memory sides.
// Performs byte-lane alignment, strobe generation and load sign/zero extension.
// Optional macro YSYX_LSU_MISALIGN_TRAP_EN: misaligned accesses return resp_err instead of
// being forced down to the size boundary.
module ysyx_lsu #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
) (
    input logic        clk,
    input logic        rst,
    ysyx_lsu_if.slave  bus
);
    localparam int unsigned STRB_W = XLEN / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [OFF_W-1:0]  req_off, size_mask, eff_off;
    logic [STRB_W-1:0] base_strb;
    logic [XLEN-1:0]   wdata_shift;
    logic [STRB_W-1:0] wstrb_shift;
    logic              illegal_size, req_err;

    logic [XLEN-1:0]   rd_shift, rd_mask, rd_ext;
    logic              rd_sign;

    // Decode the incoming request: lane offset, strobes, shifted store data, error detection
    always_comb begin
        req_off = bus.req_addr[OFF_W-1:0];
        case (bus.req_size)
            2'b00:   begin size_mask = '0;          base_strb = STRB_W'(1);  end
            2'b01:   begin size_mask = OFF_W'(1);   base_strb = STRB_W'(3);  end
            2'b10:   begin size_mask = OFF_W'(3);   base_strb = STRB_W'(15); end
            default: begin size_mask = '1;          base_strb = '1;          end
        endcase
        // A dword access does not exist on a 32-bit bus
        illegal_size = (XLEN == 32) && (bus.req_size == 2'b11);
`ifdef YSYX_LSU_MISALIGN_TRAP_EN
        eff_off = req_off;
        req_err = illegal_size || ((req_off & size_mask) != '0);
`else
        // Misaligned addresses are silently rounded down to the access size
        eff_off = req_off & ~size_mask;
        req_err = illegal_size;
`endif
        wdata_shift = bus.req_wdata << {eff_off, 3'b000};
        wstrb_shift = base_strb << eff_off;
    end

    // Extract the addressed lanes of the returned bus word and extend to XLEN
    always_comb begin
        rd_shift = bus.mem_rdata >> {off_q, 3'b000};
        case (size_q)
            2'b00:   begin rd_mask = XLEN'(8'hFF);         rd_sign = rd_shift[7];      end
            2'b01:   begin rd_mask = XLEN'(16'hFFFF);      rd_sign = rd_shift[15];     end
            2'b10:   begin rd_mask = XLEN'(32'hFFFF_FFFF); rd_sign = rd_shift[31];     end
            default: begin rd_mask = '1;                   rd_sign = rd_shift[XLEN-1]; end
        endcase
        rd_ext = (rd_shift & rd_mask) | ((rd_sign && !uns_q) ? ~rd_mask : '0);
    end

    // State and captured-transaction registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            off_q   <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            off_q   <= off_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: capture on accept, hand off to memory, capture load data, respond
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        off_d   = off_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    addr_d  = {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    wen_d   = bus.req_wen;
                    wdata_d = wdata_shift;
                    wstrb_d = bus.req_wen ? wstrb_shift : '0;
                    off_d   = eff_off;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    rdata_d = '0;
                    err_d   = req_err;
                    // Faulting accesses never reach memory
                    state_d = req_err ? StResp : StReq;
                end
            end
            StReq: begin
                if (bus.mem_req_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (bus.mem_resp_valid) begin
                    rdata_d = wen_q ? '0 : rd_ext;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (bus.resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are gated by state so every idle-time output reads as zero
    always_comb begin
        bus.req_ready     = (state_q == StIdle);
        bus.mem_req_valid = (state_q == StReq);
        bus.mem_addr      = (state_q == StReq) ? addr_q  : '0;
        bus.mem_wen       = (state_q == StReq) ? wen_q   : 1'b0;
        bus.mem_wdata     = (state_q == StReq) ? wdata_q : '0;
        bus.mem_wstrb     = (state_q == StReq) ? wstrb_q : '0;
        bus.resp_valid    = (state_q == StResp);
        bus.resp_rdata    = (state_q == StResp) ? rdata_q : '0;
        bus.resp_err      = (state_q == StResp) ? err_q   : 1'b0;
    end
endmodule

// File: tb/tb_ysyx_lsu.sv
// tb_ysyx_lsu: table-driven check of ysyx_lsu (XLEN=32) with a response scoreboard.
module tb_ysyx_lsu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_lsu_if #(.XLEN(32), .ADDR_W(32)) bus ();

    ysyx_lsu #(.XLEN(32), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        wen;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_wstrb;
        logic [31:0] e_rdata;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(logic wen, logic [1:0] size, logic uns, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] rdata, logic [31:0] e_addr,
                                logic [31:0] e_wdata, logic [3:0] e_wstrb,
                                logic [31:0] e_rdata, logic e_err);
        vec_t v;
        v.wen = wen; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_wstrb = e_wstrb;
        v.e_rdata = e_rdata; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".req_ready"},     64'(bus.req_ready),     64'd1);
        chk({tag, ".mem_req_valid"}, 64'(bus.mem_req_valid), 64'd0);
        chk({tag, ".mem_addr"},      64'(bus.mem_addr),      64'd0);
        chk({tag, ".mem_wen"},       64'(bus.mem_wen),       64'd0);
        chk({tag, ".mem_wdata"},     64'(bus.mem_wdata),     64'd0);
        chk({tag, ".mem_wstrb"},     64'(bus.mem_wstrb),     64'd0);
        chk({tag, ".resp_valid"},    64'(bus.resp_valid),    64'd0);
        chk({tag, ".resp_rdata"},    64'(bus.resp_rdata),    64'd0);
        chk({tag, ".resp_err"},      64'(bus.resp_err),      64'd0);
    endtask

    // One complete access; stalls insert backpressure, stray injects early mem_resp_valid
    task automatic do_access(input vec_t v, input int req_stall, input int resp_stall,
                             input bit stray);
        vec_t e;
        int   n;
        chk("accept.req_ready", 64'(bus.req_ready), 64'd1);
        bus.req_valid    = 1'b1;
        bus.req_wen      = v.wen;
        bus.req_size     = v.size;
        bus.req_unsigned = v.uns;
        bus.req_addr     = v.addr;
        bus.req_wdata    = v.wdata;
        exp_q.push_back(v);
        step();
        // Scramble request fields so only captured values can reach memory
        bus.req_valid    = 1'b0;
        bus.req_addr     = 32'hDEAD_BEEF;
        bus.req_wdata    = 32'h5555_AAAA;
        bus.req_size     = 2'b00;
        bus.req_unsigned = ~v.uns;
        if (v.e_err) begin
            chk("err.mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
        end else begin
            for (int i = 0; i <= req_stall; i++) begin
                chk("req.mem_req_valid", 64'(bus.mem_req_valid), 64'd1);
                chk("req.req_ready",     64'(bus.req_ready),     64'd0);
                chk("req.mem_addr",      64'(bus.mem_addr),      64'(v.e_addr));
                chk("req.mem_wen",       64'(bus.mem_wen),       64'(v.wen));
                chk("req.mem_wdata",     64'(bus.mem_wdata),     64'(v.e_wdata));
                chk("req.mem_wstrb",     64'(bus.mem_wstrb),     64'(v.e_wstrb));
                if (i == req_stall) bus.mem_req_ready = 1'b1;
                if (stray && (i == 0 || i == req_stall)) begin
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_rdata      = ~v.rdata;
                end
                step();
                bus.mem_req_ready  = 1'b0;
                bus.mem_resp_valid = 1'b0;
            end
            chk("wait.mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
            chk("wait.resp_valid",    64'(bus.resp_valid),    64'd0);
            bus.mem_resp_valid = 1'b1;
            bus.mem_rdata      = v.rdata;
            step();
            bus.mem_resp_valid = 1'b0;
            bus.mem_rdata      = 32'h5A5A_5A5A;
        end
        n = 0;
        while (!bus.resp_valid && n < 8) begin
            step();
            n++;
        end
        chk("resp.latency", 64'(n), 64'd0);
        for (int i = 0; i <= resp_stall; i++) begin
            chk("resp.resp_valid", 64'(bus.resp_valid), 64'd1);
            chk("resp.req_ready",  64'(bus.req_ready),  64'd0);
            if (i == resp_stall) begin
                bus.resp_ready = 1'b1;
                e = exp_q.pop_front();
                chk("resp.rdata", 64'(bus.resp_rdata), 64'(e.e_rdata));
                chk("resp.err",   64'(bus.resp_err),   64'(e.e_err));
            end else begin
                chk("hold.rdata", 64'(bus.resp_rdata), 64'(v.e_rdata));
            end
            step();
        end
        bus.resp_ready = 1'b0;
        chk("done.resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("done.req_ready",  64'(bus.req_ready),  64'd1);
    endtask

    initial begin
        bus.req_valid      = 1'b0;
        bus.req_wen        = 1'b0;
        bus.req_size       = 2'b00;
        bus.req_unsigned   = 1'b0;
        bus.req_addr       = '0;
        bus.req_wdata      = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = '0;
        bus.resp_ready     = 1'b0;

        //        wen   sz     uns   addr          wdata         rdata
        //        e_addr        e_wdata       strb   e_rdata       err
        vecs.push_back(mk(1'b0, 2'd0, 1'b0, 32'h8000_0003, 32'h0, 32'h80AB_CDEF,
                          32'h8000_0000, 32'h0, 4'b0000, 32'hFFFF_FF80, 1'b0));
        vecs.push_back(mk(1'b0, 2'd1, 1'b1, 32'h8000_0002, 32'h0, 32'hF00D_1234,
                          32'h8000_0000, 32'h0, 4'b0000, 32'h0000_F00D, 1'b0));
        vecs.push_back(mk(1'b0, 2'd1, 1'b0, 32'h8000_0002, 32'h0, 32'hF00D_1234,
                          32'h8000_0000, 32'h0, 4'b0000, 32'hFFFF_F00D, 1'b0));
        vecs.push_back(mk(1'b1, 2'd1, 1'b0, 32'h8000_0002, 32'h1234_ABCD, 32'hDEAD_BEEF,
                          32'h8000_0000, 32'hABCD_0000, 4'b1100, 32'h0, 1'b0));
        vecs.push_back(mk(1'b1, 2'd0, 1'b0, 32'h8000_0001, 32'h0000_00A5, 32'h0,
                          32'h8000_0000, 32'h0000_A500, 4'b0010, 32'h0, 1'b0));
        vecs.push_back(mk(1'b0, 2'd0, 1'b1, 32'h8000_0001, 32'h0, 32'h1234_9876,
                          32'h8000_0000, 32'h0, 4'b0000, 32'h0000_0098, 1'b0));
        vecs.push_back(mk(1'b1, 2'd2, 1'b0, 32'h8000_0004, 32'hCAFE_BABE, 32'h0,
                          32'h8000_0004, 32'hCAFE_BABE, 4'b1111, 32'h0, 1'b0));
        vecs.push_back(mk(1'b0, 2'd1, 1'b0, 32'h8000_0000, 32'h0, 32'h1234_7FFF,
                          32'h8000_0000, 32'h0, 4'b0000, 32'h0000_7FFF, 1'b0));
        vecs.push_back(mk(1'b0, 2'd0, 1'b0, 32'h8000_0002, 32'h0, 32'h00FF_0000,
                          32'h8000_0000, 32'h0, 4'b0000, 32'hFFFF_FFFF, 1'b0));
        vecs.push_back(mk(1'b0, 2'd0, 1'b1, 32'h8000_0002, 32'h0, 32'h00FF_0000,
                          32'h8000_0000, 32'h0, 4'b0000, 32'h0000_00FF, 1'b0));
        // Dword on a 32-bit bus is always an error
        vecs.push_back(mk(1'b0, 2'd3, 1'b0, 32'h8000_0000, 32'h0, 32'h0,
                          32'h0, 32'h0, 4'b0000, 32'h0, 1'b1));
`ifdef YSYX_LSU_MISALIGN_TRAP_EN
        vecs.push_back(mk(1'b0, 2'd2, 1'b0, 32'h8000_0001, 32'h0, 32'h1122_3344,
                          32'h0, 32'h0, 4'b0000, 32'h0, 1'b1));
        vecs.push_back(mk(1'b1, 2'd1, 1'b0, 32'h8000_0003, 32'h0000_BEEF, 32'h0,
                          32'h0, 32'h0, 4'b0000, 32'h0, 1'b1));
`else
        vecs.push_back(mk(1'b0, 2'd2, 1'b0, 32'h8000_0001, 32'h0, 32'h1122_3344,
                          32'h8000_0000, 32'h0, 4'b0000, 32'h1122_3344, 1'b0));
        vecs.push_back(mk(1'b1, 2'd1, 1'b0, 32'h8000_0003, 32'h0000_BEEF, 32'h0,
                          32'h8000_0000, 32'hBEEF_0000, 4'b1100, 32'h0, 1'b0));
`endif

        step();
        check_idle("in_reset");
        rst = 1'b0;
        step();
        check_idle("after_reset");

        // Zero-wait, back-to-back table
        foreach (vecs[i]) do_access(vecs[i], 0, 0, 1'b0);

        // Backpressure on both sides plus stray responses during REQ
        do_access(vecs[1], 3, 2, 1'b1);
        do_access(vecs[3], 2, 1, 1'b1);

        // Reset while waiting for memory; the late response must be dropped
        bus.req_valid = 1'b1;
        bus.req_wen   = 1'b0;
        bus.req_size  = 2'd2;
        bus.req_addr  = 32'h8000_0000;
        step();
        bus.req_valid     = 1'b0;
        chk("rst_seq.mem_req_valid", 64'(bus.mem_req_valid), 64'd1);
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        chk("rst_seq.in_wait", 64'(bus.mem_req_valid), 64'd0);
        rst = 1'b1;
        #1;
        check_idle("rst_async");
        step();
        rst = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h1234_5678;
        step();
        bus.mem_resp_valid = 1'b0;
        check_idle("stale_resp");
        step();
        check_idle("stale_resp2");
        do_access(mk(1'b0, 2'd2, 1'b0, 32'h8000_0000, 32'h0, 32'hA5A5_0001,
                     32'h8000_0000, 32'h0, 4'b0000, 32'hA5A5_0001, 1'b0), 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
